rv32i_lsu: RTL and testbench

//  Load/store unit serving the MEMORYACCESS stage of the unpipelined rv32i core.
//  - Start: a one-cycle MEMORYACCESS stage strobe, with the ALU address and rs2.
//  - Runs one req/ack transaction on the data-memory port.
//  - Steers store bytes; extracts and sign/zero-extends load data.
//  - Holds the stage controller via lsu_stall until the access completes, errors or times out.

---
 rtl/rv32i_lsu_pkg.sv | 32 +++
 rtl/rv32i_lsu_if.sv | 26 ++
 rtl/rv32i_lsu_align.sv | 72 +++++++
 rtl/rv32i_lsu.sv | 169 ++++++++++++++++
 tb/tb_rv32i_lsu.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module : rv32i_lsu_pkg
// Brief  : funct3 encodings, LSU state encoding and decode helper.
// Rev    : 1.0
// ============================================================================
package rv32i_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } lsu_state_t;

    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
        if (is_load)
            return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                   (f3 == F3_LBU) || (f3 == F3_LHU);
        return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_lsu_if.sv
`default_nettype none
// ============================================================================
// Module : rv32i_lsu_if
// Brief  : Data-memory req/ack port between the LSU (master) and memory.
// Rev    : 1.0
// ============================================================================
interface rv32i_lsu_if;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ack;
    logic [31:0] d_rdata;

    modport master (
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_ack, d_rdata
    );

    modport slave (
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_ack, d_rdata
    );
endinterface
`default_nettype wire

// File: rtl/rv32i_lsu_align.sv
`default_nettype none
// ============================================================================
// Module : rv32i_lsu_align
// Brief  : Combinational access decode, store lane steering, load extraction.
// Rev    : 1.0
// ============================================================================
module rv32i_lsu_align
    import rv32i_lsu_pkg::*;
(
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_rs2,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_lane,
    input  logic [31:0] i_rdata,
    output logic        o_legal,
    output logic        o_misaligned,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_load_data
);

    logic        w_half;
    logic        w_word;
    logic [7:0]  w_byte;
    logic [15:0] w_hword;

    always_comb begin
        o_legal      = (i_is_load | i_is_store) & f3_legal(i_is_load, i_funct3);
        w_half       = (i_funct3[1:0] == 2'b01);
        w_word       = (i_funct3[1:0] == 2'b10);
        o_misaligned = o_legal & ((w_half & i_lane[0]) | (w_word & (i_lane != 2'b00)));
    end

    always_comb begin
        o_wdata = i_rs2;
        o_wstrb = 4'b1111;
        case (i_funct3)
            F3_SB: begin
                o_wdata = {4{i_rs2[7:0]}};
                o_wstrb = 4'b0001 << i_lane;
            end
            F3_SH: begin
                o_wdata = {2{i_rs2[15:0]}};
                o_wstrb = 4'b0011 << i_lane;
            end
            default: ;
        endcase
    end

    // Lane chosen by the captured address, not the live one.
    always_comb begin
        case (i_ld_lane)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_hword = i_ld_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_ld_funct3)
            F3_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_load_data = {{16{w_hword[15]}}, w_hword};
            F3_LBU:  o_load_data = {24'd0, w_byte};
            F3_LHU:  o_load_data = {16'd0, w_hword};
            default: o_load_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv32i_lsu.sv
`default_nettype none
// ============================================================================
// Module : rv32i_lsu
// Brief  : Load/store unit: one req/ack data-bus access per MEMORYACCESS strobe.
// Rev    : 1.0
// ============================================================================
module rv32i_lsu
    import rv32i_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        opcode_load,
    input  logic        opcode_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] rs2,
    rv32i_lsu_if.master dbus,
    output logic [31:0] load_data,
    output logic        lsu_stall,
    output logic        done,
    output logic        misaligned,
    output logic        bus_err
);

    localparam int unsigned            c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0]     c_TMO_LAST = c_CNT_W'(TIMEOUT - 1);

    lsu_state_t          r_state;
    lsu_state_t          w_state_nxt;
    logic                w_is_load;
    logic                w_is_store;
    logic                w_legal;
    logic                w_mis;
    logic [31:0]         w_wdata;
    logic [3:0]          w_wstrb;
    logic [31:0]         w_load_ext;
    logic                w_access;
    logic                w_enter_req;
    logic                w_capture;
    logic                w_set_mis;
    logic                w_set_err;

    logic                r_req;
    logic                r_we;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_wstrb;
    logic                r_is_load;
    logic [2:0]          r_ld_funct3;
    logic [1:0]          r_ld_lane;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [31:0]         r_load_data;
    logic                r_mis;
    logic                r_err;

    // A simultaneous load+store flag pair is decoded as a load.
    assign w_is_load  = opcode_load;
    assign w_is_store = opcode_store & ~opcode_load;
    assign w_access   = start & w_legal;

    rv32i_lsu_align u_align (
        .i_is_load    (w_is_load),
        .i_is_store   (w_is_store),
        .i_funct3     (funct3),
        .i_lane       (addr[1:0]),
        .i_rs2        (rs2),
        .i_ld_funct3  (r_ld_funct3),
        .i_ld_lane    (r_ld_lane),
        .i_rdata      (dbus.d_rdata),
        .o_legal      (w_legal),
        .o_misaligned (w_mis),
        .o_wdata      (w_wdata),
        .o_wstrb      (w_wstrb),
        .o_load_data  (w_load_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_enter_req = 1'b0;
        w_capture   = 1'b0;
        w_set_mis   = 1'b0;
        w_set_err   = 1'b0;
        lsu_stall   = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                lsu_stall = w_access;
                if (start) begin
                    if (w_access && !w_mis) begin
                        w_state_nxt = S_REQ;
                        w_enter_req = 1'b1;
                    end else begin
                        w_state_nxt = S_DONE;
                        w_set_mis   = w_access & w_mis;
                    end
                end
            end
            S_REQ: begin
                lsu_stall = 1'b1;
                // An ack arriving on the final counted cycle still completes normally.
                if (dbus.d_ack) begin
                    w_state_nxt = S_DONE;
                    w_capture   = r_is_load;
                end else if (r_cnt == c_TMO_LAST) begin
                    w_state_nxt = S_DONE;
                    w_set_err   = 1'b1;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_is_load   <= 1'b0;
            r_ld_funct3 <= '0;
            r_ld_lane   <= '0;
            r_cnt       <= '0;
            r_load_data <= '0;
            r_mis       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_req <= (w_state_nxt == S_REQ);
            r_mis <= w_set_mis;
            r_err <= w_set_err;
            if (w_enter_req) begin
                r_we        <= w_is_store;
                r_addr      <= {addr[31:2], 2'b00};
                r_wdata     <= w_is_store ? w_wdata : 32'd0;
                r_wstrb     <= w_is_store ? w_wstrb : 4'b0000;
                r_is_load   <= w_is_load;
                r_ld_funct3 <= funct3;
                r_ld_lane   <= addr[1:0];
                r_cnt       <= '0;
            end else if (r_state == S_REQ) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_capture) r_load_data <= w_load_ext;
        end
    end

    assign dbus.d_req   = r_req;
    assign dbus.d_we    = r_we;
    assign dbus.d_addr  = r_addr;
    assign dbus.d_wdata = r_wdata;
    assign dbus.d_wstrb = r_wstrb;
    assign load_data    = r_load_data;
    assign misaligned   = r_mis;
    assign bus_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_lsu.sv
`default_nettype none
// ============================================================================
// Module : tb_rv32i_lsu
// Brief  : Self-checking bench: directed vector table, reset sequences, random accesses.
// Rev    : 1.0
// ============================================================================
module tb_rv32i_lsu;

    localparam int TMO = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        opcode_load;
    logic        opcode_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] load_data;
    logic        lsu_stall;
    logic        done;
    logic        misaligned;
    logic        bus_err;

    rv32i_lsu_if dbus ();

    rv32i_lsu #(.TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .opcode_load  (opcode_load),
        .opcode_store (opcode_store),
        .funct3       (funct3),
        .addr         (addr),
        .rs2          (rs2),
        .dbus         (dbus),
        .load_data    (load_data),
        .lsu_stall    (lsu_stall),
        .done         (done),
        .misaligned   (misaligned),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        is_ld;
        bit        is_st;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] rs2;
        bit [31:0] rdata;
        int        ack_lat;   // REQ cycle carrying d_ack; 0 = never
        bit        exp_none;
        bit        exp_mis;
        bit        exp_err;
        bit [3:0]  exp_wstrb;
        bit [31:0] exp_wdata;
        bit [31:0] exp_load;
    } vec_t;

    int        n_pass  = 0;
    int        n_total = 0;
    bit [31:0] m_load  = 32'd0;

    task automatic chk(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s %s: got 0x%08h expected 0x%08h", tag, what, act, exp);
    endtask

    function automatic vec_t mk(bit ld, bit st, bit [2:0] f3, bit [31:0] a, bit [31:0] d,
                                bit [31:0] rd, int lat, bit none, bit mis, bit err,
                                bit [3:0] strb, bit [31:0] wd, bit [31:0] ldv);
        vec_t v;
        v.is_ld = ld; v.is_st = st; v.f3 = f3; v.addr = a; v.rs2 = d; v.rdata = rd;
        v.ack_lat = lat; v.exp_none = none; v.exp_mis = mis; v.exp_err = err;
        v.exp_wstrb = strb; v.exp_wdata = wd; v.exp_load = ldv;
        return v;
    endfunction

    // Reference: access size in bytes, alignment by modulo, data via shifts and masks.
    function automatic vec_t model(bit ld, bit st, bit [2:0] f3, bit [31:0] a,
                                   bit [31:0] d, bit [31:0] rd, int lat);
        vec_t      v;
        bit        legal;
        int        sz;
        int        lane;
        bit [31:0] mask;
        bit [31:0] val;
        v = mk(ld, st, f3, a, d, rd, lat, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        if (ld)      legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        else if (st) legal = (f3 < 3);
        else         legal = 1'b0;
        if (!legal) return v;
        v.exp_none = 1'b0;
        sz   = 1 << f3[1:0];
        lane = int'(a % 4);
        v.exp_mis = ((a % sz) != 0);
        if (v.exp_mis) return v;
        v.exp_err = !(lat >= 1 && lat <= TMO);
        if (st) begin
            v.exp_wstrb = 4'(((1 << sz) - 1) << lane);
            if (sz == 1)      v.exp_wdata = {24'd0, d[7:0]} * 32'h0101_0101;
            else if (sz == 2) v.exp_wdata = {16'd0, d[15:0]} * 32'h0001_0001;
            else              v.exp_wdata = d;
        end else begin
            mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
            val  = (rd >> (8 * lane)) & mask;
            if (!f3[2] && sz < 4 && val[8 * sz - 1]) val = val | ~mask;
            v.exp_load = val;
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered and left one time unit after a rising edge, with the DUT idle.
    task automatic run_access(input vec_t v, input string tag);
        bit acked;
        bit [31:0] exp_addr;
        exp_addr = {v.addr[31:2], 2'b00};
        acked    = 1'b0;
        start = 1'b1; opcode_load = v.is_ld; opcode_store = v.is_st;
        funct3 = v.f3; addr = v.addr; rs2 = v.rs2;
        #1;
        chk(tag, "stall_at_start", lsu_stall, !v.exp_none);
        step();
        start = 1'b0; funct3 = 3'($urandom); addr = $urandom; rs2 = $urandom;
        if (!v.exp_none && !v.exp_mis) begin
            chk(tag, "d_we", dbus.d_we, v.is_st);
            chk(tag, "d_wstrb", dbus.d_wstrb, v.exp_wstrb);
            if (v.is_st) chk(tag, "d_wdata", dbus.d_wdata, v.exp_wdata);
            chk(tag, "done_in_req", done, 1'b0);
            for (int c = 1; c <= TMO; c++) begin
                chk(tag, "d_req_held", dbus.d_req, 1'b1);
                chk(tag, "d_addr", dbus.d_addr, exp_addr);
                chk(tag, "stall_in_req", lsu_stall, 1'b1);
                if (c == v.ack_lat) begin
                    dbus.d_ack = 1'b1; dbus.d_rdata = v.rdata; acked = 1'b1;
                end else begin
                    dbus.d_ack = 1'b0; dbus.d_rdata = $urandom;
                end
                start = 1'($urandom); opcode_load = 1'($urandom); opcode_store = 1'($urandom);
                step();
                dbus.d_ack = 1'b0;
                if (acked) break;
            end
            if (acked && v.is_ld) m_load = v.exp_load;
            chk(tag, "bus_err", bus_err, v.exp_err);
            chk(tag, "misaligned", misaligned, 1'b0);
        end else begin
            chk(tag, "misaligned", misaligned, v.exp_mis);
            chk(tag, "bus_err", bus_err, 1'b0);
        end
        chk(tag, "done", done, 1'b1);
        chk(tag, "d_req_after", dbus.d_req, 1'b0);
        chk(tag, "stall_in_done", lsu_stall, 1'b0);
        chk(tag, "load_data", load_data, m_load);
        start = 1'b0;
        step();
        chk(tag, "done_cleared", done, 1'b0);
    endtask

    initial begin
        vec_t tbl[18];
        vec_t v;
        bit   ld, st;
        rst_n = 1'b0; start = 1'b0; opcode_load = 1'b0; opcode_store = 1'b0;
        funct3 = 3'd0; addr = 32'd0; rs2 = 32'd0;
        dbus.d_ack = 1'b0; dbus.d_rdata = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset", "d_req", dbus.d_req, 1'b0);
        chk("reset", "d_we", dbus.d_we, 1'b0);
        chk("reset", "d_addr", dbus.d_addr, 32'd0);
        chk("reset", "d_wdata", dbus.d_wdata, 32'd0);
        chk("reset", "d_wstrb", dbus.d_wstrb, 4'd0);
        chk("reset", "load_data", load_data, 32'd0);
        chk("reset", "done", done, 1'b0);
        chk("reset", "misaligned", misaligned, 1'b0);
        chk("reset", "bus_err", bus_err, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        step();

        //            ld st f3    addr         rs2          rdata       lat none mis err strb  wdata         load
        tbl[0]  = mk(0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0,        1, 0, 0, 0, 4'hF, 32'hDEADBEEF, 32'h0);
        tbl[1]  = mk(0, 1, 3'd0, 32'h103, 32'h000000A5, 32'h0,        2, 0, 0, 0, 4'h8, 32'hA5A5A5A5, 32'h0);
        tbl[2]  = mk(0, 1, 3'd1, 32'h102, 32'h00001234, 32'h0,        1, 0, 0, 0, 4'hC, 32'h12341234, 32'h0);
        tbl[3]  = mk(1, 0, 3'd0, 32'h203, 32'h0,        32'h80FF7F01, 1, 0, 0, 0, 4'h0, 32'h0, 32'hFFFFFF80);
        tbl[4]  = mk(1, 0, 3'd4, 32'h201, 32'h0,        32'h80FF7F01, 3, 0, 0, 0, 4'h0, 32'h0, 32'h0000007F);
        tbl[5]  = mk(1, 0, 3'd1, 32'h202, 32'h0,        32'h80FF7F01, 1, 0, 0, 0, 4'h0, 32'h0, 32'hFFFF80FF);
        tbl[6]  = mk(1, 0, 3'd5, 32'h200, 32'h0,        32'h80FF7F01, 2, 0, 0, 0, 4'h0, 32'h0, 32'h00007F01);
        tbl[7]  = mk(1, 0, 3'd2, 32'h102, 32'h0,        32'h0,        1, 0, 1, 0, 4'h0, 32'h0, 32'h0);
        tbl[8]  = mk(0, 1, 3'd1, 32'h101, 32'h5555,     32'h0,        1, 0, 1, 0, 4'h0, 32'h0, 32'h0);
        tbl[9]  = mk(1, 0, 3'd2, 32'h300, 32'h0,        32'h0,        0, 0, 0, 1, 4'h0, 32'h0, 32'h0);
        tbl[10] = mk(1, 0, 3'd2, 32'h300, 32'h0,        32'h11223344, 4, 0, 0, 0, 4'h0, 32'h0, 32'h11223344);
        tbl[11] = mk(1, 0, 3'd3, 32'h200, 32'h0,        32'h0,        1, 1, 0, 0, 4'h0, 32'h0, 32'h0);
        tbl[12] = mk(0, 0, 3'd2, 32'h200, 32'h0,        32'h0,        1, 1, 0, 0, 4'h0, 32'h0, 32'h0);
        tbl[13] = mk(0, 1, 3'd0, 32'h101, 32'hFFFFFF3C, 32'h0,        1, 0, 0, 0, 4'h2, 32'h3C3C3C3C, 32'h0);
        tbl[14] = mk(1, 0, 3'd1, 32'h203, 32'h0,        32'h0,        1, 0, 1, 0, 4'h0, 32'h0, 32'h0);
        tbl[15] = mk(0, 1, 3'd3, 32'h104, 32'h12345678, 32'h0,        1, 1, 0, 0, 4'h0, 32'h0, 32'h0);
        tbl[16] = mk(1, 0, 3'd5, 32'h202, 32'h0,        32'h0,        0, 0, 0, 1, 4'h0, 32'h0, 32'h0);
        tbl[17] = mk(1, 0, 3'd0, 32'h200, 32'h0,        32'h000000FF, 1, 0, 0, 0, 4'h0, 32'h0, 32'hFFFFFFFF);

        foreach (tbl[i]) run_access(tbl[i], $sformatf("vec%0d", i));

        // Asynchronous reset in the middle of a pending load.
        start = 1'b1; opcode_load = 1'b1; opcode_store = 1'b0; funct3 = 3'd2; addr = 32'h200;
        step();
        start = 1'b0;
        chk("rst_mid", "d_req_before", dbus.d_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid", "d_req", dbus.d_req, 1'b0);
        chk("rst_mid", "done", done, 1'b0);
        chk("rst_mid", "load_data", load_data, 32'd0);
        chk("rst_mid", "d_addr", dbus.d_addr, 32'd0);
        m_load = 32'd0;
        @(negedge clk) rst_n = 1'b1;
        step();
        run_access(tbl[0], "post_rst");

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0:       begin ld = 1'b0; st = 1'b0; end
                1, 2, 3: begin ld = 1'b0; st = 1'b1; end
                default: begin ld = 1'b1; st = 1'b0; end
            endcase
            v = model(ld, st, 3'($urandom), $urandom, $urandom, $urandom,
                      int'($urandom_range(0, TMO + 1)));
            run_access(v, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
